// File: rtl/serial_frame_ctrl.sv
// Frame controller for a bit-serial command/response link: sequences tclk/trst/dq_en/sr_en over one frame.
// Latency: busy one cycle after start is sampled; no backpressure, start is ignored while a frame is running.
module serial_frame_ctrl #(
    parameter int WR_BITS   = 8,
    parameter int RD_BITS   = 10,
    parameter int DIV       = 1,
    parameter int FRAME_LEN = 40,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rd_mode,
    output logic             busy,
    output logic             done,
    output logic             tclk,
    output logic             trst,
    output logic             dq_en,
    output logic             sr_en,
    output logic [CNT_W-1:0] bit_idx
);

    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0]  PH_MAX = PH_W'(DIV - 1);
    localparam logic [CNT_W-1:0] FC_MAX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] WR_MAX = CNT_W'(WR_BITS - 1);
    localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(RD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI, S_END
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             mode_q, mode_d;
    logic             ph_last;

    assign ph_last = (ph_q == PH_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            bit_idx_q   <= '0;
            ph_q        <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            bit_idx_q   <= bit_idx_d;
            ph_q        <= ph_d;
            mode_q      <= mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        ph_d        = ph_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        // Frame counter runs from LOAD onward and parks at the last frame cycle.
        if (state_q != S_IDLE && frame_cnt_q != FC_MAX)
            frame_cnt_d = frame_cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                frame_cnt_d = '0;
                bit_idx_d   = '0;
                ph_d        = '0;
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = rd_mode;
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: begin
                state_d = S_WR_LO;
                ph_d    = '0;
            end
            S_WR_LO: begin
                ph_d = ph_q + PH_W'(1);
                if (ph_last) begin
                    ph_d    = '0;
                    state_d = S_WR_HI;
                end
            end
            S_WR_HI: begin
                ph_d = ph_q + PH_W'(1);
                if (ph_last) begin
                    ph_d = '0;
                    if (bit_idx_q < WR_MAX) begin
                        bit_idx_d = bit_idx_q + CNT_W'(1);
                        state_d   = S_WR_LO;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = mode_q ? S_RD_LO : S_END;
                    end
                end
            end
            S_RD_LO: begin
                ph_d = ph_q + PH_W'(1);
                if (ph_last) begin
                    ph_d    = '0;
                    state_d = S_RD_HI;
                end
            end
            S_RD_HI: begin
                ph_d = ph_q + PH_W'(1);
                if (ph_last) begin
                    ph_d = '0;
                    if (bit_idx_q < RD_MAX) begin
                        bit_idx_d = bit_idx_q + CNT_W'(1);
                        state_d   = S_RD_LO;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = S_END;
                    end
                end
            end
            S_END: begin
                // A start seen in the final END cycle chains straight into the next frame.
                if (frame_cnt_q == FC_MAX) begin
                    frame_cnt_d = '0;
                    if (start) begin
                        state_d = S_LOAD;
                        mode_d  = rd_mode;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                frame_cnt_d = '0;
                bit_idx_d   = '0;
                ph_d        = '0;
            end
        endcase
    end

    always_comb begin
        tclk  = 1'b1;
        trst  = 1'b1;
        dq_en = 1'b0;
        sr_en = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: trst = 1'b0;
            S_WR_LO: begin
                tclk  = 1'b0;
                dq_en = 1'b1;
                sr_en = (ph_q == '0);
            end
            S_WR_HI: dq_en = 1'b1;
            S_RD_LO: begin
                tclk  = 1'b0;
                sr_en = (ph_q == '0);
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_END) && (frame_cnt_q == FC_MAX);
    assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench: two controller instances (default and DIV=2 short frame) checked against a cycle-stamped event scoreboard.
module tb_serial_frame_ctrl;

    typedef struct {
        int   cyc;
        logic dq;
        int   idx;
        logic is_done;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, rd_a, start_b, rd_b;
    logic       busy_a, done_a, tclk_a, trst_a, dq_a, sr_a;
    logic       busy_b, done_b, tclk_b, trst_b, dq_b, sr_b;
    logic [7:0] idx_a, idx_b;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t qa[$];
    ev_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        if (o !== e) begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, o, e);
        end
    endtask

    serial_frame_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .rd_mode(rd_a),
        .busy(busy_a), .done(done_a), .tclk(tclk_a), .trst(trst_a),
        .dq_en(dq_a), .sr_en(sr_a), .bit_idx(idx_a)
    );

    serial_frame_ctrl #(.WR_BITS(4), .RD_BITS(4), .DIV(2), .FRAME_LEN(10), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .rd_mode(rd_b),
        .busy(busy_b), .done(done_b), .tclk(tclk_b), .trst(trst_b),
        .dq_en(dq_b), .sr_en(sr_b), .bit_idx(idx_b)
    );

    // Expected shift strobes and done pulse of one frame whose LOAD is seen at cycle l.
    task automatic push_frame(input bit dut_b, input int l, input bit rd, output int done_c);
        int  w, r, dv, f, t;
        ev_t e;
        if (dut_b) begin w = 4; r = 4;  dv = 2; f = 10; end
        else       begin w = 8; r = 10; dv = 1; f = 40; end
        t = 2;
        for (int b = 0; b < w; b++) begin
            e = '{cyc: l + t, dq: 1'b1, idx: b, is_done: 1'b0};
            if (dut_b) qb.push_back(e); else qa.push_back(e);
            t += 2 * dv;
        end
        if (rd) begin
            for (int b = 0; b < r; b++) begin
                e = '{cyc: l + t, dq: 1'b0, idx: b, is_done: 1'b0};
                if (dut_b) qb.push_back(e); else qa.push_back(e);
                t += 2 * dv;
            end
        end
        done_c = (t > f - 1) ? l + t : l + f - 1;
        e = '{cyc: done_c, dq: 1'b0, idx: 0, is_done: 1'b1};
        if (dut_b) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < t) begin
            errors++;
            $error("FAIL wait_expired: cycle %0d never reached (at %0d)", t, cyc);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $error("FAIL watchdog: simulation did not finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (sr_a || done_a)) begin
            check("a_event_expected", (qa.size() > 0), 1'b1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a_event_kind", done_a, e.is_done);
                check("a_event_cycle", cyc, e.cyc);
                check("a_event_dq_en", dq_a, e.dq);
                check("a_event_bit_idx", idx_a, 8'(e.idx));
            end
        end
        if (rst_n && (sr_b || done_b)) begin
            check("b_event_expected", (qb.size() > 0), 1'b1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b_event_kind", done_b, e.is_done);
                check("b_event_cycle", cyc, e.cyc);
                check("b_event_dq_en", dq_b, e.dq);
                check("b_event_bit_idx", idx_b, 8'(e.idx));
            end
        end
    end

    initial begin
        int l, d, l2, d2;
        rst_n = 1'b0; start_a = 1'b0; rd_a = 1'b0; start_b = 1'b0; rd_b = 1'b0;
        #1;
        check("rst_tclk", tclk_a, 1'b1);
        check("rst_trst", trst_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_dq_en", dq_a, 1'b0);
        check("rst_sr_en", sr_a, 1'b0);
        check("rst_bit_idx", idx_a, 8'd0);
        check("rst_b_busy", busy_b, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_tclk", tclk_a, 1'b1);
            check("idle_trst", trst_a, 1'b0);
            check("idle_busy", busy_a, 1'b0);
            check("idle_done", done_a, 1'b0);
        end

        l = cyc + 1;
        start_a = 1'b1; rd_a = 1'b1;
        push_frame(1'b0, l, 1'b1, d);
        @(negedge clk);
        start_a = 1'b0; rd_a = 1'b0;
        check("f1_load_busy", busy_a, 1'b1);
        check("f1_load_trst", trst_a, 1'b0);
        wait_cyc(l + 1);
        check("f1_start_trst", trst_a, 1'b1);
        wait_cyc(l + 2);
        check("f1_wrlo_tclk", tclk_a, 1'b0);
        check("f1_wrlo_dq_en", dq_a, 1'b1);
        wait_cyc(l + 3);
        check("f1_wrhi_tclk", tclk_a, 1'b1);
        check("f1_wrhi_sr_en", sr_a, 1'b0);
        wait_cyc(l + 18);
        check("f1_rdlo_dq_en", dq_a, 1'b0);
        check("f1_rdlo_tclk", tclk_a, 1'b0);
        wait_cyc(d);
        check("f1_done_busy", busy_a, 1'b1);
        wait_cyc(d + 1);
        check("f1_after_busy", busy_a, 1'b0);
        check("f1_queue_drained", qa.size(), 0);

        l = cyc + 1;
        start_a = 1'b1; rd_a = 1'b0;
        push_frame(1'b0, l, 1'b0, d);
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(l + 18);
        check("f2_end_tclk", tclk_a, 1'b1);
        check("f2_end_dq_en", dq_a, 1'b0);
        check("f2_end_busy", busy_a, 1'b1);
        wait_cyc(d + 1);
        check("f2_after_busy", busy_a, 1'b0);
        check("f2_queue_drained", qa.size(), 0);

        l = cyc + 1;
        start_b = 1'b1; rd_b = 1'b1;
        push_frame(1'b1, l, 1'b1, d);
        @(negedge clk);
        start_b = 1'b0;
        wait_cyc(l + 2);
        check("b_lo0_tclk", tclk_b, 1'b0);
        wait_cyc(l + 3);
        check("b_lo1_tclk", tclk_b, 1'b0);
        check("b_lo1_sr_en", sr_b, 1'b0);
        wait_cyc(l + 4);
        check("b_hi0_tclk", tclk_b, 1'b1);
        wait_cyc(l + 5);
        check("b_hi1_tclk", tclk_b, 1'b1);
        wait_cyc(d);
        check("b_done_busy", busy_b, 1'b1);
        wait_cyc(d + 1);
        check("b_after_busy", busy_b, 1'b0);
        check("b_queue_drained", qb.size(), 0);

        l = cyc + 1;
        start_a = 1'b1; rd_a = 1'b0;
        push_frame(1'b0, l, 1'b0, d);
        l2 = d + 1;
        push_frame(1'b0, l2, 1'b1, d2);
        wait_cyc(l + 1);
        rd_a = 1'b1;
        wait_cyc(l2);
        check("b2b_load_busy", busy_a, 1'b1);
        check("b2b_load_trst", trst_a, 1'b0);
        start_a = 1'b0;
        wait_cyc(d2 + 1);
        check("b2b_after_busy", busy_a, 1'b0);
        check("b2b_queue_drained", qa.size(), 0);

        l = cyc + 1;
        start_a = 1'b1; rd_a = 1'b1;
        push_frame(1'b0, l, 1'b1, d);
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(l + 12);
        check("abort_pre_tclk", tclk_a, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tclk", tclk_a, 1'b1);
        check("abort_trst", trst_a, 1'b0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_dq_en", dq_a, 1'b0);
        check("abort_bit_idx", idx_a, 8'd0);
        qa.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(cyc + 45);
        check("abort_no_restart", busy_a, 1'b0);

        l = cyc + 1;
        start_a = 1'b1; rd_a = 1'b1;
        push_frame(1'b0, l, 1'b1, d);
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(d + 1);
        check("post_abort_busy", busy_a, 1'b0);
        check("post_abort_queue_drained", qa.size(), 0);
        check("final_b_queue_drained", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
